multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Moore-style control FSM for the multi-cycle MIPS datapath, replacing the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states, stretching memory states with a ready handshake. Adds BNE, a memory-timeout trap, and a retired-instruction counter. Sits between the instruction register and all datapath muxes and enables.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `MEM_TIMEOUT`, 16: maximum wait cycles in a memory state before trapping (≥1).
- `clk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `opcode`  in  6  IR[31:26]. Sampled in DECODE only.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `branch_ne`  out  1 each  PC enable, conditional PC enable, and branch sense (1 = BNE).
- `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1 each  memory-side controls.
- `reg_dst`, `mem_2_reg`, `reg_write`, `alu_src_a`  out  1 each  register-file and ALU-A controls.
- `alu_src_b`  out  2  ALU B mux: 00 = reg, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = R-type (funct).
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- `trap`  out  1  sticky error flag.
- `instr_retired`  out  CNT_W  count of completed instructions.

## Operation
- Opcodes: R = 0x00, J = 0x02, BEQ = 0x04, BNE = 0x05, ADDI = 0x08, LW = 0x23, SW = 0x2B. Any other opcode in DECODE sends the FSM to TRAP.
- States and transitions:
  - FETCH → DECODE on `mem_ready`.
  - DECODE → MEM_ADDR on LW/SW; EXEC_R on R; EXEC_I on ADDI; BRANCH on BEQ/BNE; JUMP on J.
  - MEM_ADDR → MEM_RD on LW, MEM_WR on SW.
  - MEM_RD → MEM_WB on `mem_ready`; MEM_WR → FETCH on `mem_ready`.
  - EXEC_R → R_WB; EXEC_I → I_WB.
  - MEM_WB, R_WB, I_WB, BRANCH and JUMP each → FETCH.
  - TRAP is absorbing.
- Outputs asserted per state. All unlisted outputs are 0.
  - FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00; `ir_write` = `pc_write` = `mem_ready` (Mealy).
  - DECODE: `alu_src_b`=11, `alu_op`=00.
  - MEM_ADDR and EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEM_RD: `mem_read`=1, `i_or_d`=1. MEM_WR: `mem_write`=1, `i_or_d`=1.
  - MEM_WB: `mem_2_reg`=1, `reg_write`=1. I_WB: `reg_write`=1. R_WB: `reg_dst`=1, `reg_write`=1.
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `branch_ne` = opcode-was-BNE (latched in DECODE).
  - JUMP: `pc_write`=1, `pc_source`=10.
  - TRAP: `trap`=1.
- Wait counter: cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle the state is held with `mem_ready`=0. When it reaches `MEM_TIMEOUT` with `mem_ready` still 0, the FSM goes to TRAP. `mem_ready` in the same cycle wins over the timeout.
- `instr_retired` increments by 1 on the final cycle of each instruction: MEM_WB, MEM_WR with ready, R_WB, I_WB, BRANCH, JUMP. It wraps modulo 2^CNT_W and never increments in TRAP.

## Timing
- Reset: on the cycle `rst`=1 the next state is FETCH and the counters clear. While `rst`=1, every output is forced to 0 and `instr_retired`=0, including a mid-instruction or TRAP reset. The first fetch request appears the cycle after `rst` falls.
- Latency with zero wait (ready in the first cycle of each memory state):
  - BEQ/BNE and J: 3 cycles.
  - R, ADDI and SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds one cycle.
- Memory handshake: request is held stable (`mem_read`/`mem_write`, `i_or_d`) until the cycle `mem_ready`=1. Exactly one write-enable pulse per access.
- `opcode` is ignored outside DECODE.

## Test plan
- Reset mid-LW (in MEM_RD) → all outputs 0 during reset; FETCH with `mem_read`=1 the cycle after release; `instr_retired`=0.
- R-type, `mem_ready` tied high → state sequence FETCH, DECODE, EXEC_R, R_WB over 4 cycles; `alu_op`=10 in EXEC_R; `reg_dst`=`reg_write`=1 in R_WB; count 0→1.
- LW with 3 wait cycles in MEM_RD → 8 cycles total; `mem_read` and `i_or_d`=1 held for 4 cycles; `mem_2_reg`=`reg_write`=1 for exactly 1 cycle.
- BEQ then BNE → 3 cycles each; `pc_write_cond`=1 in BRANCH both times; `branch_ne` 0 then 1; count advances by 2.
- Illegal opcode 0x3F → TRAP the cycle after DECODE; `trap` stays 1 for 20+ cycles; no enables asserted; count frozen.
- `MEM_TIMEOUT`=4, `mem_ready` held low in FETCH → TRAP after 4 wait cycles. Repeat with `mem_ready` rising on the 4th wait cycle → DECODE, no trap.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory handshake, timeout trap and retire counter
module multicycle_control_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_2_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             trap,
    output logic [CNT_W-1:0] instr_retired
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // Wait counter only needs to reach MEM_TIMEOUT-1: the next idle cycle traps instead of counting.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB,
        S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              is_sw_q, is_sw_d;
    logic              is_bne_q, is_bne_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              timeout;
    logic              retire;

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        wait_q    <= wait_d;
        is_sw_q   <= is_sw_d;
        is_bne_q  <= is_bne_d;
        retired_q <= retired_d;
    end

    always_comb begin
        state_d  = state_q;
        is_sw_d  = is_sw_q;
        is_bne_d = is_bne_q;
        retire   = 1'b0;
        timeout  = !mem_ready && (wait_q == WAIT_LAST);
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
            end
            S_DECODE: begin
                is_sw_d  = (opcode == OP_SW);
                is_bne_d = (opcode == OP_BNE);
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_R:           state_d = S_EXEC_R;
                    OP_ADDI:        state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC_R: state_d = S_R_WB;
            S_EXEC_I: state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase

        // Only memory states self-loop; any state change restarts the wait count.
        wait_d    = (state_d == state_q) ? wait_q + 1'b1 : '0;
        retired_d = retired_q + CNT_W'(retire);

        if (rst) begin
            state_d   = S_FETCH;
            wait_d    = '0;
            is_sw_d   = 1'b0;
            is_bne_d  = 1'b0;
            retired_d = '0;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_2_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        trap          = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEM_ADDR, S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_MEM_WB: begin
                    mem_2_reg = 1'b1;
                    reg_write = 1'b1;
                end
                S_I_WB: reg_write = 1'b1;
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = is_bne_q;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign instr_retired = rst ? '0 : retired_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed bench for multicycle_control_unit
module tb_multicycle_control_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_2_reg, reg_write, alu_src_a, trap;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] instr_retired;
    logic [17:0] obs;
    int          checks = 0;
    int          failures = 0;

    multicycle_control_unit #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_2_reg(mem_2_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .trap(trap), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_2_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap};

    //                              pw pwc bne iod mr mw irw rd m2r rw asa asb aop psrc trap
    localparam logic [17:0] F_RDY  = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [17:0] F_WAIT = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [17:0] DEC    = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [17:0] MADDR  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] MRD    = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] MWR    = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] MWB    = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] IWB    = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [17:0] RWB    = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [17:0] EXR    = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [17:0] BEQ_O  = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] BNE_O  = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] JMP    = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [17:0] TRP    = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;
    localparam logic [17:0] ZERO   = 18'b0;
    localparam logic [5:0]  JUNK   = 6'h3F;

    // Drive inputs, check outputs mid-cycle, then advance to 1 time unit after the next edge.
    task automatic cyc(input logic rdy, input logic [5:0] op, input logic [17:0] exp, input string tag);
        mem_ready = rdy;
        opcode    = op;
        #1;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input logic [31:0] exp, input string tag);
        checks++;
        assert (instr_retired === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, instr_retired, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 6'h00, ZERO, "reset_outputs");
        chk_cnt(32'd0, "reset_count");
        rst = 1'b0;

        // R-type, ready tied high
        cyc(1'b1, JUNK, F_RDY, "r_fetch");
        cyc(1'b1, 6'h00, DEC, "r_decode");
        cyc(1'b1, JUNK, EXR, "r_exec");
        cyc(1'b1, JUNK, RWB, "r_wb");
        chk_cnt(32'd1, "r_count");

        // LW with three wait cycles in MEM_RD
        cyc(1'b1, JUNK, F_RDY, "lw_fetch");
        cyc(1'b1, 6'h23, DEC, "lw_decode");
        cyc(1'b1, JUNK, MADDR, "lw_addr");
        for (int i = 0; i < 3; i++) cyc(1'b0, JUNK, MRD, "lw_rd_wait");
        cyc(1'b1, JUNK, MRD, "lw_rd_done");
        cyc(1'b1, JUNK, MWB, "lw_wb");
        cyc(1'b1, JUNK, F_RDY, "lw_wb_once");
        chk_cnt(32'd2, "lw_count");

        // SW with one wait cycle
        cyc(1'b1, 6'h2B, DEC, "sw_decode");
        cyc(1'b1, JUNK, MADDR, "sw_addr");
        cyc(1'b0, JUNK, MWR, "sw_wr_wait");
        chk_cnt(32'd2, "sw_no_early_retire");
        cyc(1'b1, JUNK, MWR, "sw_wr_done");
        chk_cnt(32'd3, "sw_count");

        // ADDI, BEQ, BNE, J
        cyc(1'b1, JUNK, F_RDY, "addi_fetch");
        cyc(1'b1, 6'h08, DEC, "addi_decode");
        cyc(1'b1, JUNK, MADDR, "addi_exec");
        cyc(1'b1, JUNK, IWB, "addi_wb");
        cyc(1'b1, JUNK, F_RDY, "beq_fetch");
        cyc(1'b1, 6'h04, DEC, "beq_decode");
        cyc(1'b1, 6'h05, BEQ_O, "beq_branch");
        cyc(1'b1, JUNK, F_RDY, "bne_fetch");
        cyc(1'b1, 6'h05, DEC, "bne_decode");
        cyc(1'b1, 6'h04, BNE_O, "bne_branch");
        chk_cnt(32'd6, "branch_count");
        cyc(1'b1, JUNK, F_RDY, "j_fetch");
        cyc(1'b1, 6'h02, DEC, "j_decode");
        cyc(1'b1, JUNK, JMP, "j_jump");
        chk_cnt(32'd7, "j_count");

        // Reset in the middle of an LW (MEM_RD)
        cyc(1'b1, JUNK, F_RDY, "lw2_fetch");
        cyc(1'b1, 6'h23, DEC, "lw2_decode");
        cyc(1'b1, JUNK, MADDR, "lw2_addr");
        cyc(1'b0, JUNK, MRD, "lw2_rd_wait");
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk_cnt(32'd0, "mid_reset_count");
        cyc(1'b1, JUNK, ZERO, "mid_reset_outputs");
        rst = 1'b0;

        // Release: fetch with ready rising on the 4th wait cycle (counter at MEM_TIMEOUT-1)
        cyc(1'b0, JUNK, F_WAIT, "fetch_after_reset");
        chk_cnt(32'd0, "count_after_reset");
        cyc(1'b0, JUNK, F_WAIT, "fetch_wait2");
        cyc(1'b0, JUNK, F_WAIT, "fetch_wait3");
        cyc(1'b1, JUNK, F_RDY, "ready_on_4th");
        cyc(1'b1, 6'h00, DEC, "no_trap_decode");
        cyc(1'b1, JUNK, EXR, "r2_exec");
        cyc(1'b1, JUNK, RWB, "r2_wb");
        chk_cnt(32'd1, "r2_count");

        // Fetch timeout: four idle cycles then TRAP
        for (int i = 0; i < 4; i++) cyc(1'b0, JUNK, F_WAIT, "timeout_wait");
        cyc(1'b0, JUNK, TRP, "timeout_trap");
        cyc(1'b1, 6'h00, TRP, "timeout_trap_sticky");
        chk_cnt(32'd1, "timeout_count_frozen");

        // Reset out of TRAP
        rst = 1'b1;
        cyc(1'b1, JUNK, ZERO, "trap_reset_outputs");
        rst = 1'b0;

        // J then illegal opcode
        cyc(1'b1, JUNK, F_RDY, "j2_fetch");
        cyc(1'b1, 6'h02, DEC, "j2_decode");
        cyc(1'b1, JUNK, JMP, "j2_jump");
        cyc(1'b1, JUNK, F_RDY, "ill_fetch");
        cyc(1'b1, 6'h3F, DEC, "ill_decode");
        for (int i = 0; i < 22; i++) begin
            logic [5:0] rop;
            rop = 6'($urandom_range(0, 63));
            cyc(1'($urandom_range(0, 1)), rop, TRP, "ill_trap");
        end
        chk_cnt(32'd1, "ill_count_frozen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
